// File: rtl/pc_fetch_bpu_if.sv
// Fetch/branch-predictor bundle: fetch control and EX resolution in, fetch PC and prediction out.
// The master side (EX / test driver) issues control; the slave side is the fetch unit.
interface pc_fetch_bpu_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  en_f;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  upd_valid;
  logic [DATA_WIDTH-1:0] upd_pc;
  logic                  upd_taken;
  logic [DATA_WIDTH-1:0] upd_target;
  logic                  upd_is_jump;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] inc_PC;
  logic                  predict_taken;
  logic [DATA_WIDTH-1:0] predict_target;

  modport master (
    output en_f, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
    input  PC, inc_PC, predict_taken, predict_target
  );

  modport slave (
    input  en_f, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
    output PC, inc_PC, predict_taken, predict_target
  );
endinterface

// File: rtl/pc_fetch_bpu.sv
// Fetch-stage PC register with a direct-mapped BTB of tag/target/saturating-counter entries.
// Updates from EX land at the clock edge, so a same-cycle lookup sees the previous contents.
module pc_fetch_bpu #(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          BTB_ENTRIES = 16,
  parameter int unsigned          CTR_BITS    = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_bpu_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW = DATA_WIDTH - IdxW - 2;

  localparam logic [CTR_BITS-1:0] CtrMax    = '1;
  localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CtrWeakNt = CtrWeakT - CTR_BITS'(1);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q [BTB_ENTRIES];
  logic [TagW-1:0]       tag_q   [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] tgt_q   [BTB_ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q   [BTB_ENTRIES];

  logic [IdxW-1:0] rd_idx, upd_idx;
  logic [TagW-1:0] rd_tag, upd_tag;
  logic            rd_hit, upd_hit;

  logic                  upd_we;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [DATA_WIDTH-1:0] upd_tgt;

  logic unused_upd_lsb;
  assign unused_upd_lsb = ^bus.upd_pc[1:0];

  // Lookup on the current fetch PC
  assign rd_idx = pc_q[IdxW+1:2];
  assign rd_tag = pc_q[DATA_WIDTH-1:IdxW+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign bus.PC             = pc_q;
  assign bus.inc_PC         = pc_q + DATA_WIDTH'(4);
  assign bus.predict_taken  = rd_hit && ctr_q[rd_idx][CTR_BITS-1];
  assign bus.predict_target = rd_hit ? tgt_q[rd_idx] : '0;

  assign upd_idx = bus.upd_pc[IdxW+1:2];
  assign upd_tag = bus.upd_pc[DATA_WIDTH-1:IdxW+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_we  = 1'b0;
    upd_ctr = ctr_q[upd_idx];
    upd_tgt = tgt_q[upd_idx];
    if (bus.upd_valid) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (bus.upd_is_jump) begin
          upd_ctr = CtrMax;
          upd_tgt = bus.upd_target;
        end else if (bus.upd_taken) begin
          if (upd_ctr != CtrMax) upd_ctr = upd_ctr + CTR_BITS'(1);
          upd_tgt = bus.upd_target;
        end else if (upd_ctr != '0) begin
          upd_ctr = upd_ctr - CTR_BITS'(1);
        end
      end else if (bus.upd_taken) begin
        // Allocation only on taken outcomes; not-taken misses leave the entry alone
        upd_we  = 1'b1;
        upd_ctr = bus.upd_is_jump ? CtrMax : CtrWeakT;
        upd_tgt = bus.upd_target;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (!bus.en_f) begin
      pc_d = pc_q;
    end else if (bus.predict_taken) begin
      pc_d = bus.predict_target;
    end else begin
      pc_d = bus.inc_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CtrWeakNt;
      end
    end else begin
      pc_q <= pc_d;
      if (upd_we) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_tgt;
        ctr_q[upd_idx]   <= upd_ctr;
      end
    end
  end

endmodule
